// File: rtl/ring_input_buffer_if.sv
// ----------------------------------------------------------------------------
// ring_ib_if
// Upstream link and allocator-grant bundle for one ring router input port.
//
//   in_packet      packet offered by the upstream link
//                  ([48] valid, [47:32] age key, [31:16] dest id, [15:0] payload)
//   in_valid       in_packet is offered this cycle
//   in_high        1 = high priority class, 0 = low priority class
//   in_ready_high  high class has at least one free slot
//   in_ready_low   low class has at least one free slot
//   grant_valid    allocator granted a slot this cycle
//   grant_pos      granted slot index
//   grant_in_high  granted slot belongs to the high class
//
// master: upstream link / allocator side.  slave: the input buffer.
// ----------------------------------------------------------------------------
interface ring_ib_if #(
    parameter int PACKET_SIZE = 49
) ();
    logic [PACKET_SIZE-1:0] in_packet;
    logic                   in_valid;
    logic                   in_high;
    logic                   in_ready_high;
    logic                   in_ready_low;
    logic                   grant_valid;
    logic [15:0]            grant_pos;
    logic                   grant_in_high;

    modport master (
        output in_packet, in_valid, in_high,
        output grant_valid, grant_pos, grant_in_high,
        input  in_ready_high, in_ready_low
    );

    modport slave (
        input  in_packet, in_valid, in_high,
        input  grant_valid, grant_pos, grant_in_high,
        output in_ready_high, in_ready_low
    );
endinterface

// File: rtl/ring_input_buffer.sv
// ----------------------------------------------------------------------------
// ring_input_buffer
// Per-port input stage of the ring router. Packets from the upstream link are
// stored in a high- and a low-priority slot array; every slot and its route
// code are presented to the switch allocator, which frees slots by granting
// them. Stored packets age every cycle so that a min-key pick is oldest-first.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   bus (ring_ib_if.slave)        upstream offer, readies, allocator grant
//   buffer_high_prior / _low      slot contents per class (BUFFER_SIZE slots)
//   buffer_*_route_info           per-slot route code (0 when slot empty)
//   occ_high / occ_low            occupied slot count per class
//   grant_err                     sticky: grant hit an empty / out-of-range slot
// ----------------------------------------------------------------------------
module ring_input_buffer #(
    parameter int          PACKET_SIZE = 49,
    parameter int          BUFFER_SIZE = 4,
    parameter logic [15:0] LOCAL_ID    = 16'h0000,
    parameter logic [15:0] FWD_CODE    = 16'h0001,
    parameter logic [15:0] EJECT_CODE  = 16'h0002
) (
    input  logic                                     clk,
    input  logic                                     rst,
    ring_ib_if.slave                                 bus,
    output logic [BUFFER_SIZE-1:0][PACKET_SIZE-1:0]  buffer_high_prior,
    output logic [BUFFER_SIZE-1:0][PACKET_SIZE-1:0]  buffer_low_prior,
    output logic [BUFFER_SIZE-1:0][15:0]             buffer_high_prior_route_info,
    output logic [BUFFER_SIZE-1:0][15:0]             buffer_low_prior_route_info,
    output logic [$clog2(BUFFER_SIZE):0]             occ_high,
    output logic [$clog2(BUFFER_SIZE):0]             occ_low,
    output logic                                     grant_err
);
    localparam int              IDX_W     = (BUFFER_SIZE > 1) ? $clog2(BUFFER_SIZE) : 1;
    localparam int              OCC_W     = $clog2(BUFFER_SIZE) + 1;
    localparam logic [OCC_W-1:0] OCC_FULL  = OCC_W'(BUFFER_SIZE);
    localparam logic [15:0]     POS_LIMIT = 16'(BUFFER_SIZE);
    localparam int              VALID_BIT = PACKET_SIZE - 1;

    logic [IDX_W-1:0]       grant_idx;
    logic                   grant_in_range;
    logic [15:0]            route_in;
    logic [PACKET_SIZE-1:0] packet_in;
    logic [1:0]             ready;
    logic [1:0]             grant_miss;
    logic                   grant_err_reg;
    logic                   unused_ok;

    // The incoming age key is discarded: every packet starts as "youngest".
    assign unused_ok = &{1'b0, bus.in_packet[47:32]};

    assign grant_idx      = bus.grant_pos[IDX_W-1:0];
    assign grant_in_range = (bus.grant_pos < POS_LIMIT);
    assign route_in       = (bus.in_packet[31:16] == LOCAL_ID) ? EJECT_CODE : FWD_CODE;
    assign packet_in      = {1'b1, 16'hFFFF, bus.in_packet[31:0]};

    // Class 1 = high priority, class 0 = low priority.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_class
            localparam bit IS_HIGH = (gi == 1);

            logic [PACKET_SIZE-1:0] slot_reg  [BUFFER_SIZE];
            logic [15:0]            route_reg [BUFFER_SIZE];
            logic [OCC_W-1:0]       occ_reg;
            logic [BUFFER_SIZE-1:0] occupied;
            logic [IDX_W-1:0]       wr_idx;
            logic                   accept;
            logic                   grant_sel;
            logic                   grant_hit;

            always_comb begin
                occupied = '0;
                for (int j = 0; j < BUFFER_SIZE; j++) begin
                    occupied[j] = slot_reg[j][VALID_BIT];
                end
            end

            // Lowest-index free slot from pre-edge state; a slot freed this
            // cycle is still occupied here, so it is never reused the same edge.
            always_comb begin
                wr_idx = '0;
                for (int j = BUFFER_SIZE - 1; j >= 0; j--) begin
                    if (!occupied[j]) begin
                        wr_idx = IDX_W'(j);
                    end
                end
            end

            // Ready depends only on registered occupancy, never on a grant.
            assign ready[gi]      = (occ_reg != OCC_FULL);
            assign accept         = bus.in_valid & bus.in_packet[VALID_BIT]
                                  & (bus.in_high == IS_HIGH) & ready[gi];
            assign grant_sel      = bus.grant_valid & (bus.grant_in_high == IS_HIGH);
            assign grant_hit      = grant_sel & grant_in_range & occupied[grant_idx];
            assign grant_miss[gi] = grant_sel & ~(grant_in_range & occupied[grant_idx]);

            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int j = 0; j < BUFFER_SIZE; j++) begin
                        slot_reg[j]  <= '0;
                        route_reg[j] <= '0;
                    end
                    occ_reg <= '0;
                end else begin
                    for (int j = 0; j < BUFFER_SIZE; j++) begin
                        // A write targets an empty slot and a free targets an
                        // occupied one, so the two never collide on one slot.
                        if (accept && (wr_idx == IDX_W'(j))) begin
                            slot_reg[j]  <= packet_in;
                            route_reg[j] <= route_in;
                        end else if (grant_hit && (grant_idx == IDX_W'(j))) begin
                            slot_reg[j]  <= '0;
                            route_reg[j] <= '0;
                        end else if (occupied[j] && (slot_reg[j][47:32] != 16'h0000)) begin
                            slot_reg[j][47:32] <= slot_reg[j][47:32] - 16'd1;
                        end
                    end
                    occ_reg <= occ_reg + OCC_W'(accept) - OCC_W'(grant_hit);
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            grant_err_reg <= 1'b0;
        end else if (|grant_miss) begin
            grant_err_reg <= 1'b1;
        end
    end

    genvar gj;
    generate
        for (gj = 0; gj < BUFFER_SIZE; gj++) begin : g_out
            assign buffer_high_prior[gj]            = g_class[1].slot_reg[gj];
            assign buffer_low_prior[gj]             = g_class[0].slot_reg[gj];
            assign buffer_high_prior_route_info[gj] = g_class[1].route_reg[gj];
            assign buffer_low_prior_route_info[gj]  = g_class[0].route_reg[gj];
        end
    endgenerate

    assign occ_high          = g_class[1].occ_reg;
    assign occ_low           = g_class[0].occ_reg;
    assign bus.in_ready_high = ready[1];
    assign bus.in_ready_low  = ready[0];
    assign grant_err         = grant_err_reg;
endmodule

// File: tb/tb_ring_input_buffer.sv
// ----------------------------------------------------------------------------
// tb_ring_input_buffer
// Directed stimulus against ring_input_buffer. A slot-level model (each packet
// remembered with the cycle it was written; its key is derived from elapsed
// time) is compared with the DUT on every falling edge, and literal values
// computed by hand pin the model at key points.
// ----------------------------------------------------------------------------
module tb_ring_input_buffer;
    localparam int PS = 49;
    localparam int BS = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ring_ib_if #(.PACKET_SIZE(PS)) bus ();

    logic [BS-1:0][PS-1:0] buffer_high_prior;
    logic [BS-1:0][PS-1:0] buffer_low_prior;
    logic [BS-1:0][15:0]   route_high;
    logic [BS-1:0][15:0]   route_low;
    logic [2:0]            occ_high;
    logic [2:0]            occ_low;
    logic                  grant_err;

    ring_input_buffer #(
        .PACKET_SIZE(PS), .BUFFER_SIZE(BS), .LOCAL_ID(16'h0000),
        .FWD_CODE(16'h0001), .EJECT_CODE(16'h0002)
    ) dut (
        .clk                          (clk),
        .rst                          (rst),
        .bus                          (bus),
        .buffer_high_prior            (buffer_high_prior),
        .buffer_low_prior             (buffer_low_prior),
        .buffer_high_prior_route_info (route_high),
        .buffer_low_prior_route_info  (route_low),
        .occ_high                     (occ_high),
        .occ_low                      (occ_low),
        .grant_err                    (grant_err)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    bit active = 1'b0;

    // Model: per class (1 = high, 0 = low) and slot
    bit          m_valid [2][BS];
    int          m_wcyc  [2][BS];
    logic [15:0] m_dest  [2][BS];
    logic [15:0] m_pay   [2][BS];
    bit          m_err;

    task automatic chk(input string name, input int idx, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            if (n_bad <= 40)
                $display("FAIL %s[%0d] at cycle %0d: got %h, expected %h", name, idx, cyc, act, exp);
        end
    endtask

    function automatic logic [PS-1:0] exp_slot(input int c, input int j);
        int age;
        logic [15:0] key;
        if (!m_valid[c][j]) return '0;
        age = cyc - m_wcyc[c][j];
        key = (age >= 65535) ? 16'h0000 : 16'(65535 - age);
        return {1'b1, key, m_dest[c][j], m_pay[c][j]};
    endfunction

    function automatic logic [15:0] exp_route(input int c, input int j);
        if (!m_valid[c][j]) return 16'h0000;
        return (m_dest[c][j] == 16'h0000) ? 16'h0002 : 16'h0001;
    endfunction

    function automatic int m_count(input int c);
        int n = 0;
        for (int j = 0; j < BS; j++) if (m_valid[c][j]) n++;
        return n;
    endfunction

    // Model update on every rising edge from the inputs the DUT samples.
    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            for (int c = 0; c < 2; c++)
                for (int j = 0; j < BS; j++) m_valid[c][j] = 1'b0;
            m_err = 1'b0;
        end else begin
            for (int c = 0; c < 2; c++) begin
                int cnt;
                int wi;
                bit acc;
                cnt = m_count(c);
                wi = -1;
                for (int j = 0; j < BS; j++)
                    if (!m_valid[c][j] && wi < 0) wi = j;
                acc = bus.in_valid && bus.in_packet[48] && (bus.in_high == (c == 1)) && (cnt < BS);
                if (bus.grant_valid && (bus.grant_in_high == (c == 1))) begin
                    if (bus.grant_pos < BS && m_valid[c][int'(bus.grant_pos)])
                        m_valid[c][int'(bus.grant_pos)] = 1'b0;
                    else
                        m_err = 1'b1;
                end
                if (acc) begin
                    m_valid[c][wi] = 1'b1;
                    m_wcyc[c][wi]  = cyc;
                    m_dest[c][wi]  = bus.in_packet[31:16];
                    m_pay[c][wi]   = bus.in_packet[15:0];
                end
            end
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (active) begin
            for (int j = 0; j < BS; j++) begin
                chk("hi_slot",  j, buffer_high_prior[j], exp_slot(1, j));
                chk("lo_slot",  j, buffer_low_prior[j],  exp_slot(0, j));
                chk("hi_route", j, route_high[j],        exp_route(1, j));
                chk("lo_route", j, route_low[j],         exp_route(0, j));
            end
            chk("occ_high",   0, occ_high,          m_count(1));
            chk("occ_low",    0, occ_low,           m_count(0));
            chk("ready_high", 0, bus.in_ready_high, m_count(1) != BS);
            chk("ready_low",  0, bus.in_ready_low,  m_count(0) != BS);
            chk("grant_err",  0, grant_err,         m_err);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_offer(input bit hi, input logic [15:0] dest, input logic [15:0] pay);
        bus.in_valid  = 1'b1;
        bus.in_high   = hi;
        bus.in_packet = {1'b1, 16'h1234, dest, pay};
        $display("txn offer class=%s dest=%h payload=%h", hi ? "high" : "low", dest, pay);
    endtask

    task automatic set_grant(input bit hi, input logic [15:0] pos);
        bus.grant_valid   = 1'b1;
        bus.grant_in_high = hi;
        bus.grant_pos     = pos;
        $display("txn grant class=%s pos=%0d", hi ? "high" : "low", pos);
    endtask

    task automatic clear_inputs();
        bus.in_valid      = 1'b0;
        bus.in_high       = 1'b0;
        bus.in_packet     = '0;
        bus.grant_valid   = 1'b0;
        bus.grant_in_high = 1'b0;
        bus.grant_pos     = 16'h0000;
    endtask

    task automatic offer(input bit hi, input logic [15:0] dest, input logic [15:0] pay);
        set_offer(hi, dest, pay);
        step();
        clear_inputs();
    endtask

    task automatic grant(input bit hi, input logic [15:0] pos);
        set_grant(hi, pos);
        step();
        clear_inputs();
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        repeat (2) step();
        rst = 1'b0;
        active = 1'b1;

        // Reset state
        for (int j = 0; j < BS; j++) begin
            chk("rst_hi_slot", j, buffer_high_prior[j], 64'd0);
            chk("rst_lo_slot", j, buffer_low_prior[j],  64'd0);
        end
        chk("rst_occ_high",   0, occ_high,          64'd0);
        chk("rst_occ_low",    0, occ_low,           64'd0);
        chk("rst_ready_high", 0, bus.in_ready_high, 64'd1);
        chk("rst_ready_low",  0, bus.in_ready_low,  64'd1);
        chk("rst_grant_err",  0, grant_err,         64'd0);

        // Fill the high class, slots in order
        for (int i = 0; i < BS; i++) begin
            offer(1'b1, 16'h0005, 16'(16'h0010 + i));
            chk("fill_slot",  i, buffer_high_prior[i], {15'd0, 1'b1, 16'hFFFF, 16'h0005, 16'(16'h0010 + i)});
            chk("fill_route", i, route_high[i], 64'h0001);
            chk("fill_occ",   i, occ_high, 64'(i + 1));
        end
        chk("full_ready_high", 0, bus.in_ready_high, 64'd0);
        chk("full_ready_low",  0, bus.in_ready_low,  64'd1);

        // 5th offer to a full class is dropped
        offer(1'b1, 16'h0005, 16'h0014);
        chk("drop_occ",   0, occ_high, 64'd4);
        chk("drop_slot3", 3, buffer_high_prior[3][15:0], 64'h0013);
        chk("drop_err",   0, grant_err, 64'd0);

        // Grant slot 2 with a concurrent offer while full
        set_grant(1'b1, 16'd2);
        set_offer(1'b1, 16'h0005, 16'h0020);
        step();
        clear_inputs();
        chk("gfull_slot2",  2, buffer_high_prior[2], 64'd0);
        chk("gfull_route2", 2, route_high[2], 64'd0);
        chk("gfull_occ",    0, occ_high, 64'd3);
        chk("gfull_ready",  0, bus.in_ready_high, 64'd1);
        offer(1'b1, 16'h0005, 16'h0020);
        chk("refill_slot2", 2, buffer_high_prior[2], {15'd0, 1'b1, 16'hFFFF, 16'h0005, 16'h0020});
        chk("refill_occ",   0, occ_high, 64'd4);

        // Reset while full, with a concurrent offer and grant
        rst = 1'b1;
        set_offer(1'b0, 16'h0005, 16'h0030);
        set_grant(1'b1, 16'd0);
        step();
        rst = 1'b0;
        clear_inputs();
        for (int j = 0; j < BS; j++) begin
            chk("rst2_hi_slot", j, buffer_high_prior[j], 64'd0);
            chk("rst2_lo_slot", j, buffer_low_prior[j],  64'd0);
        end
        chk("rst2_occ_high", 0, occ_high, 64'd0);
        chk("rst2_occ_low",  0, occ_low,  64'd0);

        // Bad grants: empty slot, then out of range
        grant(1'b0, 16'd1);
        chk("bad_err",  0, grant_err, 64'd1);
        chk("bad_occ",  0, occ_low,   64'd0);
        grant(1'b1, 16'd7);
        chk("oor_err",  0, grant_err, 64'd1);
        chk("oor_occ",  0, occ_high,  64'd0);

        // Offer with valid bit clear is ignored
        bus.in_valid  = 1'b1;
        bus.in_high   = 1'b0;
        bus.in_packet = {1'b0, 16'h1234, 16'h0005, 16'h0040};
        $display("txn offer class=low valid_bit=0 payload=0040");
        step();
        clear_inputs();
        chk("novalid_occ", 0, occ_low, 64'd0);

        // Ageing of one low packet, through saturation
        offer(1'b0, 16'h0005, 16'h00AA);
        chk("age_write", 0, buffer_low_prior[0], {15'd0, 1'b1, 16'hFFFF, 16'h0005, 16'h00AA});
        chk("age_route", 0, route_low[0], 64'h0001);
        repeat (10) step();
        chk("age_10", 0, buffer_low_prior[0][47:32], 64'hFFF5);
        repeat (65523) step();
        chk("age_2", 0, buffer_low_prior[0][47:32], 64'h0002);
        step();
        chk("age_1", 0, buffer_low_prior[0][47:32], 64'h0001);
        step();
        chk("age_0", 0, buffer_low_prior[0][47:32], 64'h0000);
        step();
        chk("age_sat", 0, buffer_low_prior[0][47:32], 64'h0000);
        chk("age_vld", 0, buffer_low_prior[0][48],    64'd1);

        // Eject routing
        offer(1'b0, 16'h0000, 16'h00BB);
        chk("eject_slot",  1, buffer_low_prior[1], {15'd0, 1'b1, 16'hFFFF, 16'h0000, 16'h00BB});
        chk("eject_route", 1, route_low[1], 64'h0002);
        chk("eject_occ",   0, occ_low, 64'd2);

        // Same-class write plus free
        set_grant(1'b0, 16'd0);
        set_offer(1'b0, 16'h0009, 16'h00CC);
        step();
        clear_inputs();
        chk("wf_slot2",  2, buffer_low_prior[2], {15'd0, 1'b1, 16'hFFFF, 16'h0009, 16'h00CC});
        chk("wf_route2", 2, route_low[2], 64'h0001);
        chk("wf_slot0",  0, buffer_low_prior[0], 64'd0);
        chk("wf_route0", 0, route_low[0], 64'd0);
        chk("wf_occ",    0, occ_low, 64'd2);
        chk("wf_err",    0, grant_err, 64'd1);

        step();
        active = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/ring_input_buffer.md
Name: ring_input_buffer

Overview:
- Per-port input stage of the ring router. Accepts packets from the upstream link and stores them in two slot arrays: high-priority and low-priority.
- Presents every slot, plus per-slot route info, to the downstream switch allocator.
- Frees a slot when the allocator reports a grant for it. Drives ready/backpressure upstream.
- Owns packet ageing: the allocator's min-key selection always picks the oldest packet.

Parameters:
- PACKET_SIZE, 49, packet width. Fields: [48] valid, [47:32] age key, [31:16] destination node id, [15:0] payload.
- BUFFER_SIZE, 4, slots per priority class. The allocator is fixed at 4.
- LOCAL_ID, 16'h0000, this router's node id.
- FWD_CODE, 16'h0001, route-info code for "forward along ring".
- EJECT_CODE, 16'h0002, route-info code for "eject to local port".

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- in_packet  in  PACKET_SIZE  incoming packet
- in_valid  in  1  in_packet is offered this cycle
- in_high  in  1  1 = high class, 0 = low class
- in_ready_high  out  1  high class has at least one free slot
- in_ready_low  out  1  low class has at least one free slot
- grant_valid  in  1  allocator granted a slot this cycle
- grant_pos  in  16  granted slot index
- grant_in_high  in  1  granted slot is in the high class
- buffer_high_prior  out  PACKET_SIZE x BUFFER_SIZE  high slot contents
- buffer_low_prior  out  PACKET_SIZE x BUFFER_SIZE  low slot contents
- buffer_high_prior_route_info  out  16 x BUFFER_SIZE  per-slot route code
- buffer_low_prior_route_info  out  16 x BUFFER_SIZE  per-slot route code
- occ_high  out  $clog2(BUFFER_SIZE)+1  occupied high slots
- occ_low  out  $clog2(BUFFER_SIZE)+1  occupied low slots
- grant_err  out  1  sticky: a grant targeted an empty slot or an out-of-range index

Behaviour:
- Reset (rst=1 at posedge):
  - All slots, route infos, occupancies and grant_err go to 0.
  - in_ready_high = in_ready_low = 1 from the first cycle after reset.
  - rst has priority over every other event, including a mid-cycle write or grant.
- Slot state:
  - A slot is occupied iff its bit [48] = 1.
  - Route info is 0 iff the slot is empty.
- Ready signals:
  - in_ready_x is combinational and equals (occ_x != BUFFER_SIZE).
  - in_ready_x reflects registered state only. A same-cycle grant does not raise it.
- Accept condition: in_valid & in_packet[48] & in_ready_{class}.
  - An offer with bit [48] = 0 is ignored.
  - An offer to a full class is ignored, with no storage and no error. Upstream must hold the packet.
- Write (latency 1): the accepted packet is written at the next posedge into the lowest-index free slot of its class, chosen from pre-edge state.
  - Stored [47:32] = 16'hFFFF.
  - Stored [31:0] = in_packet[31:0].
  - Stored [48] = 1.
  - Route info = EJECT_CODE if in_packet[31:16] == LOCAL_ID, else FWD_CODE.
- Ageing: each posedge, every occupied slot not being written or freed decrements [47:32] by 1, saturating at 0. Smaller key means older.
- Free (latency 1): a grant with grant_pos < BUFFER_SIZE to an occupied slot clears that slot's packet and route info to 0 at the next posedge.
  - A grant to an empty slot, or with grant_pos >= BUFFER_SIZE, changes no slot and sets grant_err. grant_err clears only on rst.
- Simultaneous write and free in the same class:
  - Both take effect.
  - The write slot is chosen from pre-edge state, so the slot being freed is never reused in that cycle.
  - occ is unchanged.
- Simultaneous write and free in different classes are independent.
- occ_x updates at the same edge: +1 on write, -1 on free.
- No combinational path from grant_* to buffer_* outputs.

Test Plan:
- Reset then idle:
  - All buffer outputs are 0, occ = 0, both readies = 1.
  - Assert rst for one cycle while 2 slots are full: all slots read 0 on the next cycle.
- Fill the high class: 4 accepted high packets with dest 16'h0005, LOCAL_ID=0.
  - Slots 0..3 filled in order; route info = 16'h0001 each.
  - occ_high = 4 and in_ready_high = 0 after the 4th edge.
  - A 5th offer is not stored.
- Ageing: one low packet written, then held 10 cycles.
  - Key = 16'hFFFF at cycle 1, then 16'hFFF5.
  - Force the age to 1 via 2 more cycles from 16'h0002: the key saturates at 0.
- Eject routing: low packet with dest = LOCAL_ID → route info = 16'h0002.
- Simultaneous full-class grant and write: high class full, grant slot 2 with a concurrent high offer.
  - Offer rejected (in_ready_high = 0). Slot 2 cleared next cycle, occ_high = 3.
  - Next cycle: offer again → stored in slot 2.
- Same-class write plus free, non-full: slots 0,1 full.
  - Grant slot 0 together with a write → write lands in slot 2, slot 0 empties, occ stays 2.
- Bad grant: grant_pos = 1 on an empty low slot → grant_err = 1 and stays 1; no slot changes.
